// File: rtl/cpu_sequencer_if.sv
// ---------------------------------------------------------------------------
// cpu_sequencer_if
//   Memory handshake bundle between the instruction sequencer and the
//   instruction/data memory ports.
//
//   Handshake: imem_req / dmem_req act as "valid" and mem_ready as "ready".
//   A request stays asserted, unchanged, on every cycle until the cycle
//   in which mem_ready is high. That cycle completes the transfer. There is
//   at most one outstanding request (instruction or data) at any time, so a
//   single mem_ready serves both ports. dmem_we qualifies dmem_req: 1 =
//   write, 0 = read. It is only meaningful while dmem_req is high.
//
//   Signals:
//     imem_req   sequencer -> memory  instruction fetch request
//     dmem_req   sequencer -> memory  data request
//     dmem_we    sequencer -> memory  data request is a write
//     mem_ready  memory -> sequencer  acknowledge for the current request
//
//   Modports:
//     master  the sequencer side
//     slave   the memory side
// ---------------------------------------------------------------------------
interface cpu_sequencer_if;
  logic imem_req;
  logic dmem_req;
  logic dmem_we;
  logic mem_ready;

  modport master (
    output imem_req,
    output dmem_req,
    output dmem_we,
    input  mem_ready
  );

  modport slave (
    input  imem_req,
    input  dmem_req,
    input  dmem_we,
    output mem_ready
  );
endinterface

// File: rtl/cpu_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_sequencer
//   Multi-cycle sequencer for the 4-bit-opcode CPU. Each instruction steps
//   through FETCH / DECODE / EXEC / MEM / WB using the control bits from the
//   combinational decoder. The sequencer drives the IR load, the PC update,
//   the memory request handshakes and the register-file write strobe. A
//   memory request left unacknowledged for MEM_TIMEOUT cycles sends the
//   sequencer to a sticky FAULT state.
//
// Parameters:
//   MEM_TIMEOUT  max cycles a memory request may wait for mem_ready (>=1)
//   CNT_W        width of the wait counter and the retired-instruction counter
//
// Build option:
//   PERF_CNT_EN  When this macro is defined, retired_count counts retired
//                instructions, wraps at 2^CNT_W, and is cleared only by rst.
//                When it is undefined, retired_count is tied to 0.
//
// Ports:
//   clk, rst        clock (rising edge); synchronous active-high reset
//   start           leave IDLE, or resume from HALT
//   reg_write, mem_read, mem_write, ldpc, halt_in
//                   decoded control bits for the instruction in IR
//   mem             memory handshake (cpu_sequencer_if.master)
//   ir_load         capture instruction register (fetch acknowledged)
//   rf_we           register-file write strobe
//   pc_inc, pc_load PC <= PC+1 / PC <= target; exactly one on retire
//   state           current state encoding (debug / checker visibility)
//   halted, fault   in HALT / in FAULT (sticky until rst)
//   retired_count   instructions retired
//
// State encoding: IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 HALT=6 FAULT=7
// ---------------------------------------------------------------------------
module cpu_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             reg_write,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             ldpc,
  input  logic             halt_in,
  cpu_sequencer_if.master  mem,
  output logic             ir_load,
  output logic             rf_we,
  output logic             pc_inc,
  output logic             pc_load,
  output logic [2:0]       state,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retired_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  state_t state_q;
  state_t state_d;

  // Control bits captured from the decoder. reg_write, mem_read and
  // mem_write are captured in DECODE. ldpc is captured in EXEC, because the
  // decoder qualifies it with the zero flag only once the operands are
  // settled. Later phases use only the captured copies.
  logic rw_q;
  logic mr_q;
  logic mw_q;
  logic ldpc_q;

  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_hit;

  logic imem_req_c;
  logic dmem_req_c;
  logic dmem_we_c;
  logic ir_load_c;
  logic rf_we_c;
  logic pc_inc_c;
  logic pc_load_c;
  logic halted_c;
  logic fault_c;

  // This is the last allowed wait cycle with no acknowledge.
  // If mem_ready arrives in that same cycle, the acknowledge wins.
  assign timeout_hit = !mem.mem_ready &&
                       (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

  // -------------------------------------------------------------------------
  // State register and captured control bits
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      ldpc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        rw_q <= reg_write;
        mr_q <= mem_read;
        mw_q <= mem_write;
      end
      if (state_q == S_EXEC) begin
        ldpc_q <= ldpc;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Wait counter. It clears on any state change, which covers every entry
  // into FETCH or MEM. It counts un-acknowledged FETCH/MEM cycles.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state_d != state_q) begin
      wait_cnt <= '0;
    end else if ((state_q == S_FETCH || state_q == S_MEM) && !mem.mem_ready) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (mem.mem_ready)    state_d = S_DECODE;
        else if (timeout_hit) state_d = S_FAULT;
      end
      S_DECODE: begin
        state_d = halt_in ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        if (mr_q || mw_q) state_d = S_MEM;
        else if (rw_q)    state_d = S_WB;
        else              state_d = S_FETCH;
      end
      S_MEM: begin
        // A load, or a store that also writes a register, still needs WB.
        if (mem.mem_ready)    state_d = (mr_q || rw_q) ? S_WB : S_FETCH;
        else if (timeout_hit) state_d = S_FAULT;
      end
      S_WB: begin
        state_d = S_FETCH;
      end
      S_HALT: begin
        // The PC already moved past the HALT instruction, so resume
        // simply fetches the next instruction.
        if (start) state_d = S_FETCH;
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic. The retire cycle is the last cycle of an instruction. It
  // raises exactly one PC strobe. In EXEC the decoder's live ldpc is used,
  // because ldpc_q has not been captured yet. In later phases the captured
  // copy is used.
  // -------------------------------------------------------------------------
  always_comb begin
    imem_req_c = 1'b0;
    dmem_req_c = 1'b0;
    dmem_we_c  = 1'b0;
    ir_load_c  = 1'b0;
    rf_we_c    = 1'b0;
    pc_inc_c   = 1'b0;
    pc_load_c  = 1'b0;
    halted_c   = 1'b0;
    fault_c    = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req_c = 1'b1;
        ir_load_c  = mem.mem_ready;
      end
      S_DECODE: begin
        pc_inc_c = halt_in;
      end
      S_EXEC: begin
        if (!mr_q && !mw_q && !rw_q) begin
          pc_load_c = ldpc;
          pc_inc_c  = !ldpc;
        end
      end
      S_MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = mw_q;
        if (mem.mem_ready && !mr_q && !rw_q) begin
          pc_load_c = ldpc_q;
          pc_inc_c  = !ldpc_q;
        end
      end
      S_WB: begin
        rf_we_c   = 1'b1;
        pc_load_c = ldpc_q;
        pc_inc_c  = !ldpc_q;
      end
      S_HALT: begin
        halted_c = 1'b1;
      end
      S_FAULT: begin
        fault_c = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign mem.imem_req = imem_req_c;
  assign mem.dmem_req = dmem_req_c;
  assign mem.dmem_we  = dmem_we_c;
  assign ir_load      = ir_load_c;
  assign rf_we        = rf_we_c;
  assign pc_inc       = pc_inc_c;
  assign pc_load      = pc_load_c;
  assign halted       = halted_c;
  assign fault        = fault_c;
  assign state        = state_q;

  // -------------------------------------------------------------------------
  // Retired-instruction counter
  // -------------------------------------------------------------------------
`ifdef PERF_CNT_EN
  logic             retire;
  logic [CNT_W-1:0] retired_q;

  assign retire = pc_inc_c | pc_load_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
    end else if (retire) begin
      retired_q <= retired_q + 1'b1;
    end
  end

  assign retired_count = retired_q;
`else
  assign retired_count = '0;
`endif

endmodule
